// File: rtl/fsm_full_pkg.sv
// fsm_full_pkg: shared definitions for the four-agent fixed-priority arbiter.
//   state_t    : 3-bit binary state encoding (IDLE, GNT0..GNT3)
//   NUM_AGENTS : number of requesting agents (fixed at 4)
package fsm_full_pkg;

   localparam int NUM_AGENTS = 4;

   // Codes 3'b101..3'b111 are unused; the arbiter recovers from them to IDLE.
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      GNT0 = 3'b001,
      GNT1 = 3'b010,
      GNT2 = 3'b011,
      GNT3 = 3'b100
   } state_t;

endpackage

// File: rtl/fsm_full_if.sv
// fsm_full_if: request/grant bundle between the bus agents and the arbiter.
//   req_0..req_3 : agent requests (agent 0 has highest priority)
//   gnt_0..gnt_3 : arbiter grants, at most one high at a time
//   state_dbg    : current arbiter state, for observation only
// Handshake: an agent raises req_x and keeps it high; the grant is held while
// req_x stays high and is taken away on the edge after req_x drops. Requests
// are level-sensitive and only seen on rising clock edges; a request pulse
// that never spans an edge is never granted. Losing agents must keep their
// request asserted until they are granted.
interface fsm_full_if;
   import fsm_full_pkg::*;

   logic   req_0;
   logic   req_1;
   logic   req_2;
   logic   req_3;
   logic   gnt_0;
   logic   gnt_1;
   logic   gnt_2;
   logic   gnt_3;
   state_t state_dbg;

   // Agent side: drives requests, observes grants.
   modport master (
      output req_0, req_1, req_2, req_3,
      input  gnt_0, gnt_1, gnt_2, gnt_3,
      input  state_dbg
   );

   // Arbiter side: observes requests, drives grants.
   modport slave (
      input  req_0, req_1, req_2, req_3,
      output gnt_0, gnt_1, gnt_2, gnt_3,
      output state_dbg
   );

endinterface

// File: rtl/fsm_full.sv
// fsm_full: four-requester, single-grant Moore arbiter with fixed priority
// (req_0 > req_1 > req_2 > req_3) and no preemption.
//   clock : system clock, rising edge
//   reset : synchronous, active-high reset (forces IDLE)
//   bus   : fsm_full_if.slave carrying req_0..3 in, gnt_0..3 and state_dbg out
// A granted agent keeps its grant while it holds its request; the arbiter
// always passes through IDLE before granting again. Grants are decoded only
// from the state register, so there is no combinational req->gnt path.
module fsm_full
   import fsm_full_pkg::*;
(
   input  logic clock,
   input  logic reset,
   fsm_full_if.slave bus
);

   state_t state_q;
   state_t state_d;

   // Registered state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Priority is only resolved in IDLE; once granted, the owner
   // is the only requester looked at, which is what blocks preemption and
   // forces an IDLE cycle between consecutive grants.
   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (bus.req_0)      state_d = GNT0;
            else if (bus.req_1) state_d = GNT1;
            else if (bus.req_2) state_d = GNT2;
            else if (bus.req_3) state_d = GNT3;
            else                state_d = IDLE;
         end
         GNT0:    state_d = bus.req_0 ? GNT0 : IDLE;
         GNT1:    state_d = bus.req_1 ? GNT1 : IDLE;
         GNT2:    state_d = bus.req_2 ? GNT2 : IDLE;
         GNT3:    state_d = bus.req_3 ? GNT3 : IDLE;
         // Unused codes fall back to IDLE on the next edge.
         default: state_d = IDLE;
      endcase
   end

   // Moore output decode; unused codes decode to all grants low.
   always_comb begin
      bus.gnt_0     = 1'b0;
      bus.gnt_1     = 1'b0;
      bus.gnt_2     = 1'b0;
      bus.gnt_3     = 1'b0;
      bus.state_dbg = state_q;
      case (state_q)
         GNT0:    bus.gnt_0 = 1'b1;
         GNT1:    bus.gnt_1 = 1'b1;
         GNT2:    bus.gnt_2 = 1'b1;
         GNT3:    bus.gnt_3 = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_fsm_full.sv
// tb_fsm_full: scoreboard bench for fsm_full. The driver applies one request
// vector per clock, advances an owner-based reference model and queues the
// expected {state, grants} seen after the next edge; the monitor pops and
// compares on every falling edge and also checks the one-hot and
// idle-between-grants properties directly on the outputs.
module tb_fsm_full;
   import fsm_full_pkg::*;

   logic clock;
   logic reset;

   fsm_full_if bus ();

   fsm_full dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard state ----------------
   logic [6:0] exp_q[$];
   int         total = 0;
   int         bad   = 0;
   int         owner = -1;       // model: index of granted agent, -1 = none
   logic [3:0] prev_gnt = 4'b0000;

   // ---------------- driver ----------------
   // Drive one request vector, update the model as the next edge would,
   // queue the expectation, then advance past that edge.
   task automatic step(input logic rst, input logic [3:0] r);
      logic [6:0] e;
      reset     = rst;
      bus.req_0 = r[0];
      bus.req_1 = r[1];
      bus.req_2 = r[2];
      bus.req_3 = r[3];
      if (rst) begin
         owner = -1;
      end else if (owner < 0) begin
         for (int i = NUM_AGENTS - 1; i >= 0; i--)
            if (r[i]) owner = i;
      end else if (!r[owner]) begin
         owner = -1;
      end
      if (owner < 0) e = 7'd0;
      else           e = {3'(owner + 1), 4'(1 << owner)};
      exp_q.push_back(e);
      @(posedge clock);
      #1;
   endtask

   task automatic hold(input logic [3:0] r, input int n);
      for (int i = 0; i < n; i++) step(1'b0, r);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clock) begin
      logic [3:0] g;
      logic [6:0] act;
      logic [6:0] e;
      g   = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
      act = {3'(bus.state_dbg), g};
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (act !== e) begin
            bad++;
            $display("FAIL grant_state t=%0t actual state=%b gnt=%b required state=%b gnt=%b",
                     $time, act[6:4], act[3:0], e[6:4], e[3:0]);
         end
         total++;
         if (!$onehot0(g)) begin
            bad++;
            $display("FAIL onehot t=%0t actual gnt=%b required at most one high", $time, g);
         end
         if (g != 4'b0000 && g != prev_gnt) begin
            total++;
            if (prev_gnt != 4'b0000) begin
               bad++;
               $display("FAIL idle_gap t=%0t actual prev=%b now=%b required prev=0000",
                        $time, prev_gnt, g);
            end
         end
         prev_gnt = g;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] r;
      reset     = 1'b1;
      bus.req_0 = 1'b0;
      bus.req_1 = 1'b0;
      bus.req_2 = 1'b0;
      bus.req_3 = 1'b0;

      // Reset for two edges, then idle with no requests.
      step(1'b1, 4'b0000);
      step(1'b1, 4'b0000);
      hold(4'b0000, 3);

      // Each agent alone: grant for 5 cycles, released after the drop.
      for (int a = 0; a < NUM_AGENTS; a++) begin
         hold(4'(1 << a), 5);
         hold(4'b0000, 2);
      end

      // Priority among 1,2,3 with IDLE gaps as each winner leaves.
      hold(4'b1110, 3);
      hold(4'b1100, 3);
      hold(4'b1000, 3);
      hold(4'b0000, 2);

      // No preemption of agent 3 by agent 0.
      hold(4'b1000, 3);
      hold(4'b1001, 3);
      hold(4'b0001, 3);
      hold(4'b0000, 2);

      // Reset while agent 2 is granted, request still held afterwards.
      hold(4'b0100, 3);
      step(1'b1, 4'b0100);
      hold(4'b0100, 3);
      hold(4'b0000, 2);

      // Random traffic: sticky requests so grants are held for a while,
      // with occasional reset.
      r = 4'b0000;
      for (int c = 0; c < 1000; c++) begin
         for (int b = 0; b < NUM_AGENTS; b++)
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         step($urandom_range(0, 99) == 0, r);
      end
      hold(4'b0000, 2);

      // Let the monitor drain the last expectation.
      @(negedge clock);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain actual=%0d entries required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fsm_full.md
Name: fsm_full

Overview:
- Four-requester, single-grant arbiter built as a Moore finite-state machine.
- Fixed priority: req_0 > req_1 > req_2 > req_3.
- A granted agent keeps its grant for as long as it holds its request. The arbiter then returns to IDLE before it grants again.
- Sits between four bus agents and a shared resource. All grants are decoded from a registered state.

Parameters:
- none. Agent count is fixed at 4, and the state encoding is fixed in the shared package.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req_0  input  1  active-high request, agent 0 (highest priority)
- req_1  input  1  active-high request, agent 1
- req_2  input  1  active-high request, agent 2
- req_3  input  1  active-high request, agent 3 (lowest priority)
- gnt_0  output 1  active-high grant, agent 0
- gnt_1  output 1  active-high grant, agent 1
- gnt_2  output 1  active-high grant, agent 2
- gnt_3  output 1  active-high grant, agent 3

Behaviour:
- Interface: one clock (clock). reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- States: IDLE, GNT0, GNT1, GNT2, GNT3. Encoding is 3-bit binary: IDLE=000, GNT0=001, GNT1=010, GNT2=011, GNT3=100.
- Unused codes 101/110/111 go to IDLE on the next edge. All grants are 0 while the state register holds an unused code.
- Reset: at a rising edge with reset=1, the state becomes IDLE and all gnt_x are 0 after that edge. Reset overrides every transition, including reset asserted mid-grant. Requests are ignored while reset=1.
- Transitions from IDLE, evaluated at each edge:
  - req_0 -> GNT0
  - else req_1 -> GNT1
  - else req_2 -> GNT2
  - else req_3 -> GNT3
  - else stay in IDLE
- Transitions from GNTx: if req_x=1, stay in GNTx. If req_x=0, go to IDLE. All other requests are ignored while in GNTx; there is no preemption, even by a higher-priority requester.
- No direct GNTx->GNTy handoff. At least one IDLE cycle always separates grants.
- Outputs are a pure Moore decode of the state register: gnt_x = (state == GNTx). They are glitch-free, with no combinational path from req_* to gnt_*.
- Latency, assert: req_x high at edge k (with priority won) -> gnt_x high after edge k, i.e. valid within the same cycle that follows edge k.
- Latency, release: req_x low at edge m -> gnt_x low after edge m.
- Invariant: at most one gnt_x is high at any time (one-hot or all-zero).
- Simultaneous requests in IDLE: the lowest index wins. Losing requesters must hold their request until the winner releases and the arbiter passes through IDLE.
- A request pulse that occurs between edges and is never sampled is never granted.

Decomposition:
- Shared package fsm_full_pkg holds:
  - state typedef (3-bit enum IDLE, GNT0..GNT3) with the encodings above;
  - constant NUM_AGENTS = 4.
- Single module, organised as three blocks:
  - a registered state block;
  - a combinational next-state block, with the fixed-priority encoder inline;
  - a combinational output decode block.
- No sub-module needed.

Test Plan:
- Reset: all req=0, reset=1 for 2 edges then 0 -> all gnt=0, and all remain 0 while req stay 0.
- Single agent: req_0=1 for 5 cycles then 0 -> gnt_0=1 after the first sampling edge, held for 5 cycles, 0 after the edge sampling req_0=0. Repeat for req_1, req_2, req_3 individually with the same result on gnt_1..gnt_3.
- Priority: req_1=req_2=req_3=1 together from IDLE -> only gnt_1=1.
  - Drop req_1 -> IDLE for one cycle (all gnt=0), then gnt_2=1.
  - Drop req_2 -> IDLE, then gnt_3=1.
- No preemption: hold req_3 granted, then raise req_0 -> gnt_3 stays 1 and gnt_0 stays 0. Drop req_3 -> one IDLE cycle, then gnt_0=1.
- Reset mid-grant: gnt_2=1 with req_2 held, assert reset for 1 edge -> all gnt=0 after that edge. After deassert with req_2 still 1 -> gnt_2=1 again after the next edge.
- Invariant check: random req_* for 1000 cycles -> at most one gnt high every cycle. Every grant is preceded by an IDLE cycle, and each granted agent's req was 1 at the granting edge.
